mem_stage: RTL

Memory-access pipeline stage sitting directly downstream of the ALU. Consumes the ALU `result` (effective address for memory ops 3–11, data value for everything else) plus store data and destination register. Drives a single-outstanding req/ack data-memory port and produces a registered writeback bundle. Stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_stage_load_align.sv | 30 +++
 rtl/mem_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states,
// writeback bundle layout and alignment helpers.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  // ALU opcode range that routes an instruction through the memory port
  localparam int unsigned MEM_OP_FIRST = 3;
  localparam int unsigned MEM_OP_LAST  = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } wb_t;

  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == SZ_RSVD) ? SZ_WORD : s;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] s, input logic [1:0] a);
    logic r;
    case (s)
      SZ_HALF: r = a[0];
      SZ_WORD: r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Little-endian lane select of a read word with sign or zero extension.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{sgn_i & byte_v[7]}}, byte_v};
      SZ_HALF: data_o = {{16{sgn_i & half_v[15]}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: single-outstanding req/ack data port,
// registered writeback bundle, upstream stall while an access is pending.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_bubble,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic        in_wb_en,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_misaligned
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, sd_q, sd_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d, store_q, store_d, wb_en_q, wb_en_d;
  logic [4:0]  rd_q, rd_d;
  wb_t         wb_q, wb_d, pend_q, pend_d;
  logic        wb_valid_q, wb_valid_d, pend_vld_q, pend_vld_d;

  logic        busy, accept, is_mem, mis, complete, new_imm;
  logic [1:0]  in_size_n;
  logic [31:0] load_val;
  wb_t         done_wb, new_wb, first_wb;

  assign busy      = (state_q == ST_BUSY);
  assign stall     = busy && !mem_ack;
  assign accept    = !in_bubble && !stall;
  assign is_mem    = in_is_load || in_is_store;
  assign in_size_n = norm_size(in_size);
  assign mis       = is_mem && is_misaligned(in_size_n, in_result[1:0]);
  assign complete  = busy && mem_ack;
  assign new_imm   = accept && (!is_mem || mis);

  load_align u_load_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .sgn_i     (sgn_q),
    .data_o    (load_val)
  );

  assign done_wb = '{we:   !store_q && wb_en_q && (rd_q != 5'd0),
                     rd:   rd_q,
                     data: store_q ? 32'd0 : load_val,
                     mis:  1'b0};
  assign new_wb  = '{we:   !mis && in_wb_en && (in_rd != 5'd0),
                     rd:   in_rd,
                     data: in_result,
                     mis:  mis};
  assign first_wb = pend_vld_q ? pend_q : done_wb;

  // An immediate result accepted on the same edge as a memory completion is
  // parked one cycle in pend_q so writebacks stay in order, one per cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sd_d       = sd_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    store_d    = store_q;
    wb_en_d    = wb_en_q;
    rd_d       = rd_q;
    wb_d       = wb_q;
    wb_valid_d = 1'b0;
    pend_d     = pend_q;
    pend_vld_d = 1'b0;

    if (complete) state_d = ST_IDLE;

    if (accept && is_mem && !mis) begin
      state_d = ST_BUSY;
      addr_d  = in_result;
      sd_d    = in_store_data;
      size_d  = in_size_n;
      sgn_d   = in_signed;
      store_d = in_is_store;
      wb_en_d = in_wb_en;
      rd_d    = in_rd;
    end

    if (pend_vld_q || complete) begin
      wb_d       = first_wb;
      wb_valid_d = 1'b1;
      if (new_imm) begin
        pend_d     = new_wb;
        pend_vld_d = 1'b1;
      end
    end else if (new_imm) begin
      wb_d       = new_wb;
      wb_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      sd_q       <= '0;
      size_q     <= SZ_BYTE;
      sgn_q      <= 1'b0;
      store_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      rd_q       <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sd_q       <= sd_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      store_q    <= store_d;
      wb_en_q    <= wb_en_d;
      rd_q       <= rd_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  always_comb begin
    case (size_q)
      SZ_BYTE: begin
        mem_be    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{sd_q[7:0]}};
      end
      SZ_HALF: begin
        mem_be    = 4'b0011 << {addr_q[1], 1'b0};
        mem_wdata = {2{sd_q[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = sd_q;
      end
    endcase
    if (!busy) begin
      mem_be    = 4'b0000;
      mem_wdata = '0;
    end
  end

  assign mem_req  = busy;
  assign mem_we   = busy && store_q;
  assign mem_addr = busy ? {addr_q[31:2], 2'b00} : 32'd0;

  assign wb_valid      = wb_valid_q;
  assign wb_we         = wb_q.we;
  assign wb_rd         = wb_q.rd;
  assign wb_data       = wb_q.data;
  assign wb_misaligned = wb_q.mis;

endmodule
